test_pattern_gen: RTL and testbench

- Parametrised successor to the board-level r/g/b gradient logic.
- Sits between the video_driver pixel coordinate outputs (x, y) and its r/g/b inputs.
- Selects one of five test patterns, with optional horizontal scrolling animation driven by a frame counter.
- Mode and scroll offset are updated only at frame start, so a frame never tears.

---
 rtl/test_pattern_gen_if.sv | 32 +++
 rtl/test_pattern_gen.sv | 173 +++++++++++++++++
 tb/tb_test_pattern_gen.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_pattern_gen_if.sv
// Pixel-side bus of the test pattern generator: coordinates and controls in, colour out.
interface test_pattern_gen_if #(
  parameter int unsigned XW = 10,
  parameter int unsigned YW = 9,
  parameter int unsigned CW = 8
);

  logic              pix_en;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [2:0]        mode;
  logic              anim_en;
  logic [3*CW-1:0]   solid_rgb;
  logic [CW-1:0]     r;
  logic [CW-1:0]     g;
  logic [CW-1:0]     b;
  logic              out_valid;
  logic [15:0]       frame_cnt;

  // Coordinate/control source (video timing side, or a testbench)
  modport master (
    output pix_en, x, y, mode, anim_en, solid_rgb,
    input  r, g, b, out_valid, frame_cnt
  );

  // Pattern generator side
  modport slave (
    input  pix_en, x, y, mode, anim_en, solid_rgb,
    output r, g, b, out_valid, frame_cnt
  );

endinterface

// File: rtl/test_pattern_gen.sv
// Test pattern generator: turns pixel coordinates into one of five patterns with optional
// horizontal scrolling. Two-stage pipeline, one pixel per cycle. Mode and scroll offset are
// latched only at frame start so a frame never tears.
module test_pattern_gen #(
  parameter int unsigned WIDTH       = 640,
  parameter int unsigned HEIGHT      = 480,
  parameter int unsigned XW          = 10,
  parameter int unsigned YW          = 9,
  parameter int unsigned CW          = 8,
  parameter int unsigned TILE_LOG2   = 5,
  parameter int unsigned SCROLL_STEP = 4
) (
  input logic               CLOCK_50,
  input logic               reset_n,
  test_pattern_gen_if.slave bus
);

  localparam int unsigned XW1 = XW + 1;

  localparam logic [XW:0]   WIDTH_W  = XW1'(WIDTH);
  localparam logic [XW:0]   STEP_W   = XW1'(SCROLL_STEP);
  localparam logic [XW-1:0] WIDTH_X  = XW'(WIDTH);
  localparam logic [YW-1:0] HEIGHT_Y = YW'(HEIGHT);
  localparam logic [XW-1:0] LAST_X   = XW'(WIDTH - 1);
  localparam logic [YW-1:0] LAST_Y   = YW'(HEIGHT - 1);

  // Frame-level state
  logic [2:0]      mode_q;
  logic [XW-1:0]   off;
  logic [15:0]     frame_cnt_q;

  // Frame-start decode and effective per-pixel controls
  logic            fs;
  logic [2:0]      mode_e;
  logic [XW:0]     off_sum;
  logic [XW-1:0]   off_next;
  logic [XW-1:0]   off_e;
  logic [XW:0]     xo_sum;
  logic [XW-1:0]   xo;
  logic            oob;

  // Stage 1 registers
  logic            valid1;
  logic [2:0]      mode1;
  logic [XW-1:0]   xo1;
  logic [YW-1:0]   y1;
  logic            oob1;

  // Stage 2 colour decode
  logic [2:0]      bar;
  logic [2:0]      bar_rgb;
  logic            grid;
  logic [3*CW-1:0] col;

  // Stage 2 registers
  logic [CW-1:0]   r_q;
  logic [CW-1:0]   g_q;
  logic [CW-1:0]   b_q;
  logic            out_valid_q;

  // Frame-start detection, next scroll offset and scrolled x for the incoming pixel
  always_comb begin
    fs       = bus.pix_en && (bus.x == '0) && (bus.y == '0);
    off_sum  = {1'b0, off} + STEP_W;
    // off < WIDTH and STEP < WIDTH, so one conditional subtract is enough
    off_next = (off_sum >= WIDTH_W) ? XW'(off_sum - WIDTH_W) : off_sum[XW-1:0];
    // The frame-start pixel already sees the new mode and offset
    off_e    = (fs && bus.anim_en) ? off_next : off;
    mode_e   = fs ? bus.mode : mode_q;
    xo_sum   = {1'b0, bus.x} + {1'b0, off_e};
    xo       = (xo_sum >= WIDTH_W) ? XW'(xo_sum - WIDTH_W) : xo_sum[XW-1:0];
    oob      = (bus.x >= WIDTH_X) || (bus.y >= HEIGHT_Y);
  end

  // Frame-level state: mode, scroll offset and frame counter advance only at frame start
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      mode_q      <= '0;
      off         <= '0;
      frame_cnt_q <= '0;
    end else if (fs) begin
      mode_q      <= bus.mode;
      off         <= off_e;
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Stage 1: capture pixel attributes; valid bubbles through when pix_en is low
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      valid1 <= 1'b0;
      mode1  <= '0;
      xo1    <= '0;
      y1     <= '0;
      oob1   <= 1'b0;
    end else begin
      valid1 <= bus.pix_en;
      if (bus.pix_en) begin
        mode1 <= mode_e;
        xo1   <= xo;
        y1    <= bus.y;
        oob1  <= oob;
      end
    end
  end

  // Colour bar index from elaboration-time thresholds; last threshold passed wins
  always_comb begin
    bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (xo1 >= XW'(k * WIDTH / 8)) begin
        bar = 3'(k);
      end
    end
  end

  // Bar colours as on/off per channel {r,g,b}
  always_comb begin
    bar_rgb = 3'b000;
    unique case (bar)
      3'd0: bar_rgb = 3'b111;  // white
      3'd1: bar_rgb = 3'b110;  // yellow
      3'd2: bar_rgb = 3'b011;  // cyan
      3'd3: bar_rgb = 3'b010;  // green
      3'd4: bar_rgb = 3'b101;  // magenta
      3'd5: bar_rgb = 3'b100;  // red
      3'd6: bar_rgb = 3'b001;  // blue
      3'd7: bar_rgb = 3'b000;  // black
      default: bar_rgb = 3'b000;
    endcase
  end

  // Pattern selection for the stage-1 pixel
  always_comb begin
    col  = '0;
    grid = (xo1[TILE_LOG2-1:0] == '0) || (y1[TILE_LOG2-1:0] == '0) ||
           (xo1 == LAST_X) || (y1 == LAST_Y);
    if (!oob1) begin
      case (mode1)
        3'd0: col = bus.solid_rgb;
        3'd1: col = {bus.solid_rgb[3*CW-1:2*CW], CW'(xo1), CW'(y1)};
        3'd2: col = {{CW{bar_rgb[2]}}, {CW{bar_rgb[1]}}, {CW{bar_rgb[0]}}};
        3'd3: col = (xo1[TILE_LOG2] ^ y1[TILE_LOG2]) ? '0 : '1;
        3'd4: col = grid ? '1 : '0;
        default: col = '0;
      endcase
    end
  end

  // Stage 2: register colour for valid pixels, otherwise hold the last colour
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= valid1;
      if (valid1) begin
        r_q <= col[3*CW-1:2*CW];
        g_q <= col[2*CW-1:CW];
        b_q <= col[CW-1:0];
      end
    end
  end

  assign bus.r         = r_q;
  assign bus.g         = g_q;
  assign bus.b         = b_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_test_pattern_gen.sv
// Bench for test_pattern_gen: constant vector table, hand-written multi-cycle sequences and a
// randomized run, all checked against a pixel-level reference model.
module tb_test_pattern_gen;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
  localparam int XW     = 10;
  localparam int YW     = 9;
  localparam int CW     = 8;
  localparam int TILE   = 5;
  localparam int STEP   = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  test_pattern_gen_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  test_pattern_gen #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .XW(XW), .YW(YW), .CW(CW),
    .TILE_LOG2(TILE), .SCROLL_STEP(STEP)
  ) dut (
    .CLOCK_50(clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  int          m_mode, m_off, m_fc;
  bit          m_v1;
  int          m_mode1, m_xo1, m_y1;
  bit          m_oob1;
  bit          m_ov;
  logic [23:0] m_rgb;

  function automatic logic [23:0] colour(int m, int xo, int yy, bit oob, logic [23:0] s);
    int bar;
    if (oob) return 24'h0;
    case (m)
      0: return s;
      1: return {s[23:16], 8'(xo % 256), 8'(yy % 256)};
      2: begin
        bar = xo * 8 / WIDTH;
        case (bar)
          0: return 24'hFFFFFF;
          1: return 24'hFFFF00;
          2: return 24'h00FFFF;
          3: return 24'h00FF00;
          4: return 24'hFF00FF;
          5: return 24'hFF0000;
          6: return 24'h0000FF;
          default: return 24'h000000;
        endcase
      end
      3: return ((((xo >> TILE) & 1) ^ ((yy >> TILE) & 1)) != 0) ? 24'h0 : 24'hFFFFFF;
      4: return ((xo % (1 << TILE)) == 0 || (yy % (1 << TILE)) == 0 ||
                 xo == WIDTH - 1 || yy == HEIGHT - 1) ? 24'hFFFFFF : 24'h0;
      default: return 24'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_off = 0; m_fc = 0;
    m_v1 = 0; m_mode1 = 0; m_xo1 = 0; m_y1 = 0; m_oob1 = 0;
    m_ov = 0; m_rgb = 24'h0;
  endtask

  // Predicts the effect of one rising edge given the inputs currently driven
  task automatic model_clock(input bit pen, input int xx, input int yy);
    int xo;
    if (m_v1) m_rgb = colour(m_mode1, m_xo1, m_y1, m_oob1, bus.solid_rgb);
    m_ov = m_v1;
    if (pen && xx == 0 && yy == 0) begin
      m_mode = int'(bus.mode);
      m_fc   = (m_fc + 1) % 65536;
      if (bus.anim_en) begin
        m_off = m_off + STEP;
        if (m_off >= WIDTH) m_off = m_off - WIDTH;
      end
    end
    m_v1 = pen;
    if (pen) begin
      xo = xx + m_off;
      if (xo >= WIDTH) xo = xo - WIDTH;
      m_mode1 = m_mode;
      m_xo1   = xo;
      m_y1    = yy;
      m_oob1  = (xx >= WIDTH) || (yy >= HEIGHT);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // One clock: drive at the falling edge, compare everything against the model after the rise
  task automatic tick(input bit pen, input int xx, input int yy);
    @(negedge clk);
    bus.pix_en = pen;
    bus.x      = XW'(xx);
    bus.y      = YW'(yy);
    model_clock(pen, xx, yy);
    @(posedge clk);
    #1;
    cyc++;
    tests++;
    if (bus.out_valid !== m_ov || {bus.r, bus.g, bus.b} !== m_rgb ||
        bus.frame_cnt !== 16'(m_fc)) begin
      fails++;
      $display("FAIL cycle%0d: out_valid=%0b rgb=%06h frame_cnt=%0d, required out_valid=%0b rgb=%06h frame_cnt=%0d",
               cyc, bus.out_valid, {bus.r, bus.g, bus.b}, bus.frame_cnt, m_ov, m_rgb, m_fc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n    = 1'b0;
    bus.pix_en = 1'b0;
    model_reset();
    #1;
    chk("reset out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("reset rgb", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    chk("reset frame_cnt", {16'h0, bus.frame_cnt}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int          x;
    int          y;
    int          mode;
    logic [23:0] solid;
    logic [23:0] rgb;
    int          fc;
  } vec_t;

  vec_t vecs[24];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_en    = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.mode      = '0;
    bus.anim_en   = 1'b0;
    bus.solid_rgb = '0;
    model_reset();

    vecs[0]  = '{0,   0,   0, 24'h123456, 24'h123456, 1};
    vecs[1]  = '{0,   0,   2, 24'h000000, 24'hFFFFFF, 2};
    vecs[2]  = '{79,  5,   2, 24'h000000, 24'hFFFFFF, 2};
    vecs[3]  = '{80,  5,   2, 24'h000000, 24'hFFFF00, 2};
    vecs[4]  = '{240, 5,   2, 24'h000000, 24'h00FF00, 2};
    vecs[5]  = '{559, 5,   2, 24'h000000, 24'h0000FF, 2};
    vecs[6]  = '{560, 5,   2, 24'h000000, 24'h000000, 2};
    vecs[7]  = '{400, 5,   2, 24'h000000, 24'hFF0000, 2};
    vecs[8]  = '{320, 5,   2, 24'h000000, 24'hFF00FF, 2};
    vecs[9]  = '{160, 5,   2, 24'h000000, 24'h00FFFF, 2};
    vecs[10] = '{0,   0,   0, 24'hFFFFFF, 24'hFFFFFF, 3};
    vecs[11] = '{700, 10,  0, 24'hFFFFFF, 24'h000000, 3};
    vecs[12] = '{5,   480, 0, 24'hFFFFFF, 24'h000000, 3};
    vecs[13] = '{0,   0,   1, 24'hAB0000, 24'hAB0000, 4};
    vecs[14] = '{200, 7,   1, 24'hAB0000, 24'hABC807, 4};
    vecs[15] = '{0,   0,   3, 24'hFFFFFF, 24'hFFFFFF, 5};
    vecs[16] = '{32,  0,   3, 24'hFFFFFF, 24'h000000, 5};
    vecs[17] = '{32,  32,  3, 24'hFFFFFF, 24'hFFFFFF, 5};
    vecs[18] = '{0,   0,   4, 24'hFFFFFF, 24'hFFFFFF, 6};
    vecs[19] = '{33,  33,  4, 24'hFFFFFF, 24'h000000, 6};
    vecs[20] = '{639, 33,  4, 24'hFFFFFF, 24'hFFFFFF, 6};
    vecs[21] = '{33,  479, 4, 24'hFFFFFF, 24'hFFFFFF, 6};
    vecs[22] = '{33,  64,  4, 24'hFFFFFF, 24'hFFFFFF, 6};
    vecs[23] = '{0,   0,   5, 24'hFFFFFF, 24'h000000, 7};

    // Constant vectors: one pixel, then one idle cycle, output due now
    do_reset();
    foreach (vecs[i]) begin
      bus.mode      = 3'(vecs[i].mode);
      bus.solid_rgb = vecs[i].solid;
      tick(1'b1, vecs[i].x, vecs[i].y);
      tick(1'b0, 0, 0);
      chk($sformatf("vec%0d out_valid", i), {31'h0, bus.out_valid}, 32'h1);
      chk($sformatf("vec%0d rgb", i), {8'h0, bus.r, bus.g, bus.b}, {8'h0, vecs[i].rgb});
      chk($sformatf("vec%0d frame_cnt", i), {16'h0, bus.frame_cnt}, 32'(vecs[i].fc));
    end

    // Colour bar sweep, back-to-back pixels
    do_reset();
    bus.mode = 3'd2;
    bus.anim_en = 1'b0;
    tick(1'b1, 0, 0);
    for (int xx = 1; xx < WIDTH; xx++) tick(1'b1, xx, 5);
    tick(1'b0, 0, 0);
    chk("sweep last bar", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    tick(1'b0, 0, 0);
    chk("sweep drained", {31'h0, bus.out_valid}, 32'h0);

    // Scrolling: three frames of step 4 give offset 12
    do_reset();
    bus.mode = 3'd1;
    bus.anim_en = 1'b1;
    bus.solid_rgb = 24'h550000;
    for (int f = 0; f < 3; f++) begin
      tick(1'b1, 0, 0);
      tick(1'b1, 100, 1);
    end
    tick(1'b1, 630, 0);
    tick(1'b0, 0, 0);
    chk("scroll g at x=630", {24'h0, bus.g}, 32'd2);
    chk("scroll frame_cnt", {16'h0, bus.frame_cnt}, 32'd3);

    // Mid-frame mode change is deferred to the next frame start
    do_reset();
    bus.anim_en = 1'b0;
    bus.mode = 3'd3;
    tick(1'b1, 0, 0);
    tick(1'b1, 50, 100);
    bus.mode = 3'd4;
    tick(1'b1, 100, 200);
    tick(1'b1, 32, 0);
    tick(1'b0, 0, 0);
    chk("deferred mode checker", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    tick(1'b1, 0, 0);
    tick(1'b1, 32, 7);
    tick(1'b0, 0, 0);
    chk("next frame grid", {8'h0, bus.r, bus.g, bus.b}, 32'hFFFFFF);

    // Reset in the middle of a burst drops in-flight pixels immediately
    do_reset();
    bus.mode = 3'd0;
    bus.solid_rgb = 24'h123456;
    tick(1'b1, 0, 0);
    tick(1'b1, 1, 0);
    @(negedge clk);
    bus.pix_en = 1'b1;
    bus.x = XW'(2);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midreset out_valid", {31'h0, bus.out_valid}, 32'h0);
    chk("midreset rgb", {8'h0, bus.r, bus.g, bus.b}, 32'h0);
    chk("midreset frame_cnt", {16'h0, bus.frame_cnt}, 32'h0);
    model_reset();
    bus.pix_en = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) tick(1'b0, 0, 0);
    chk("post reset idle", {31'h0, bus.out_valid}, 32'h0);
    tick(1'b1, 0, 0);
    tick(1'b0, 0, 0);
    chk("post reset first pixel", {7'h0, bus.out_valid, bus.r, bus.g, bus.b}, 32'h1123456);

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      int sel;
      int xx;
      int yy;
      if ($urandom_range(15) == 0) bus.mode = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) bus.anim_en = 1'($urandom_range(1));
      if ($urandom_range(31) == 0) bus.solid_rgb = 24'($urandom);
      sel = $urandom_range(9);
      if (sel < 2) begin
        xx = 0; yy = 0;
      end else if (sel == 2) begin
        xx = $urandom_range((1 << XW) - 1); yy = $urandom_range((1 << YW) - 1);
      end else begin
        xx = $urandom_range(WIDTH - 1); yy = $urandom_range(HEIGHT - 1);
      end
      tick($urandom_range(3) != 0, xx, yy);
    end
    tick(1'b0, 0, 0);
    tick(1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
